// File: rtl/phase_pkg.sv
// Shared sizes, angle constants, FSM state type and CORDIC step table for the
// pole/zero phase evaluator.
package phase_pkg;

    localparam int unsigned N_ZEROS = 4;
    localparam int unsigned N_POLES = 4;
    localparam int unsigned W       = 16;
    localparam int unsigned N_ELEM  = N_ZEROS + N_POLES;
    localparam int unsigned ACC_W   = W + $clog2(N_ELEM);
    localparam int unsigned IDX_W   = $clog2(N_ELEM);
    localparam int unsigned ZIDX_W  = (N_ZEROS > 1) ? $clog2(N_ZEROS) : 1;
    localparam int unsigned PIDX_W  = (N_POLES > 1) ? $clog2(N_POLES) : 1;

    // Angles in Q3.13 radians.
    localparam logic signed [W-1:0] PHASE_PI      = 16'sd25736;
    localparam logic signed [W-1:0] PHASE_HALF_PI = 16'sd12868;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        FLUSH,
        DONE
    } state_e;

    // atan(2^-i) in Q3.13, widened by two bits for CORDIC headroom.
    function automatic logic signed [W+1:0] atan_step(input int i);
        logic signed [W+1:0] a;
        case (i)
            0:       a = 18'sd6434;
            1:       a = 18'sd3798;
            2:       a = 18'sd2007;
            3:       a = 18'sd1019;
            4:       a = 18'sd511;
            5:       a = 18'sd256;
            6:       a = 18'sd128;
            7:       a = 18'sd64;
            8:       a = 18'sd32;
            9:       a = 18'sd16;
            10:      a = 18'sd8;
            11:      a = 18'sd4;
            12:      a = 18'sd2;
            13:      a = 18'sd1;
            default: a = 18'sd0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/phase_eval_seq_if.sv
// Frame-in / phase-out handshake bundle between the diff generator, the
// phase evaluator and the magnitude/phase combiner.
interface phase_eval_seq_if;
    import phase_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [N_ZEROS*W-1:0]   zero_re;
    logic [N_ZEROS*W-1:0]   zero_im;
    logic [N_POLES*W-1:0]   pole_re;
    logic [N_POLES*W-1:0]   pole_im;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [W-1:0]    phase_out;
    logic                   busy;

    modport master (
        output in_valid, zero_re, zero_im, pole_re, pole_im, out_ready,
        input  in_ready, out_valid, phase_out, busy
    );

    modport slave (
        input  in_valid, zero_re, zero_im, pole_re, pole_im, out_ready,
        output in_ready, out_valid, phase_out, busy
    );

endinterface

// File: rtl/atan_lut.sv
// Combinational atan2(y, x) in Q3.13 radians: exact on the axes, unrolled
// CORDIC vectoring elsewhere.
module atan_lut
    import phase_pkg::*;
(
    input  logic signed [W-1:0] x_i,
    input  logic signed [W-1:0] y_i,
    output logic signed [W-1:0] angle_o
);

    localparam int unsigned IW    = W + 3;
    localparam int          NIter = 14;

    logic signed [IW-1:0]  xs;
    logic signed [IW-1:0]  ys;
    logic signed [IW-1:0]  xt;
    logic signed [W+1:0]   zs;

    always_comb begin
        xs = {{3{x_i[W-1]}}, x_i};
        ys = {{3{y_i[W-1]}}, y_i};
        xt = '0;
        zs = '0;
        // Fold the left half-plane into the right by rotating through +/-pi.
        if (x_i[W-1]) begin
            xs = -xs;
            ys = -ys;
            zs = y_i[W-1] ? -(W+2)'(PHASE_PI) : (W+2)'(PHASE_PI);
        end
        for (int i = 0; i < NIter; i++) begin
            xt = xs;
            if (!ys[IW-1]) begin
                xs = xs + (ys >>> i);
                ys = ys - (xt >>> i);
                zs = zs + atan_step(i);
            end else begin
                xs = xs - (ys >>> i);
                ys = ys + (xt >>> i);
                zs = zs - atan_step(i);
            end
        end
        angle_o = W'(zs);
        if (y_i == '0) begin
            angle_o = x_i[W-1] ? PHASE_PI : '0;
        end else if (x_i == '0) begin
            angle_o = y_i[W-1] ? -PHASE_HALF_PI : PHASE_HALF_PI;
        end
    end

endmodule

// File: rtl/phase_eval_seq.sv
// Time-multiplexed pole/zero phase sum over one shared atan_lut.
// Define ATAN_REG_EN to register the LUT output (adds a FLUSH cycle, latency 10).
module phase_eval_seq
    import phase_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    phase_eval_seq_if.slave  bus
);

    state_e                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic [N_ZEROS*W-1:0]    zre_q;
    logic [N_ZEROS*W-1:0]    zim_q;
    logic [N_POLES*W-1:0]    pre_q;
    logic [N_POLES*W-1:0]    pim_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    busy_q;
    logic signed [W-1:0]     phase_q;

    logic                    is_pole;
    logic                    last_issue;
    logic [ZIDX_W-1:0]       zidx;
    logic [PIDX_W-1:0]       pidx;
    logic signed [W-1:0]     lut_x;
    logic signed [W-1:0]     lut_y;
    logic signed [W-1:0]     lut_ang;

    logic                    acc_en;
    logic                    acc_sub;
    logic signed [W-1:0]     acc_ang;
    logic signed [ACC_W-1:0] ang_ext;

    assign is_pole    = idx_q >= IDX_W'(N_ZEROS);
    assign last_issue = idx_q == IDX_W'(N_ELEM - 1);
    assign zidx       = ZIDX_W'(idx_q);
    assign pidx       = PIDX_W'(idx_q - IDX_W'(N_ZEROS));

    always_comb begin
        if (is_pole) begin
            lut_x = pre_q[int'(pidx)*W +: W];
            lut_y = pim_q[int'(pidx)*W +: W];
        end else begin
            lut_x = zre_q[int'(zidx)*W +: W];
            lut_y = zim_q[int'(zidx)*W +: W];
        end
    end

    atan_lut u_atan_lut (
        .x_i     (lut_x),
        .y_i     (lut_y),
        .angle_o (lut_ang)
    );

`ifdef ATAN_REG_EN
    logic signed [W-1:0] ang_q;
    logic                ang_vld_q;
    logic                ang_sub_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ang_q     <= '0;
            ang_vld_q <= 1'b0;
            ang_sub_q <= 1'b0;
        end else begin
            ang_q     <= lut_ang;
            ang_vld_q <= state_q == EVAL;
            ang_sub_q <= is_pole;
        end
    end

    assign acc_en  = ang_vld_q;
    assign acc_sub = ang_sub_q;
    assign acc_ang = ang_q;
`else
    assign acc_en  = state_q == EVAL;
    assign acc_sub = is_pole;
    assign acc_ang = lut_ang;
`endif

    always_comb begin
        ang_ext = {{(ACC_W-W){acc_ang[W-1]}}, acc_ang};
        acc_d   = acc_q;
        if (acc_en) begin
            acc_d = acc_sub ? acc_q - ang_ext : acc_q + ang_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            zre_q       <= '0;
            zim_q       <= '0;
            pre_q       <= '0;
            pim_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            phase_q     <= '0;
        end else begin
            acc_q <= acc_d;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        zre_q      <= bus.zero_re;
                        zim_q      <= bus.zero_im;
                        pre_q      <= bus.pole_re;
                        pim_q      <= bus.pole_im;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= EVAL;
                    end
                end
                EVAL: begin
                    idx_q <= idx_q + 1'b1;
                    if (last_issue) begin
`ifdef ATAN_REG_EN
                        state_q     <= FLUSH;
`else
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        phase_q     <= acc_d[W-1:0];
`endif
                    end
                end
                FLUSH: begin
                    state_q     <= DONE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b1;
                    phase_q     <= acc_d[W-1:0];
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.phase_out = phase_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_phase_eval_seq.sv
// Directed bench for phase_eval_seq; latency expectation follows ATAN_REG_EN.
module tb_phase_eval_seq;
    import phase_pkg::*;

`ifdef ATAN_REG_EN
    localparam int Latency = 10;
`else
    localparam int Latency = 9;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    phase_eval_seq_if bus ();

    phase_eval_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_all(input logic signed [W-1:0] zr, input logic signed [W-1:0] zi,
                            input logic signed [W-1:0] pr, input logic signed [W-1:0] pim);
        for (int k = 0; k < int'(N_ZEROS); k++) begin
            bus.zero_re[k*W +: W] = zr;
            bus.zero_im[k*W +: W] = zi;
        end
        for (int k = 0; k < int'(N_POLES); k++) begin
            bus.pole_re[k*W +: W] = pr;
            bus.pole_im[k*W +: W] = pim;
        end
    endtask

    task automatic set_zero(input int k, input logic signed [W-1:0] re,
                            input logic signed [W-1:0] im);
        bus.zero_re[k*W +: W] = re;
        bus.zero_im[k*W +: W] = im;
    endtask

    task automatic set_pole(input int k, input logic signed [W-1:0] re,
                            input logic signed [W-1:0] im);
        bus.pole_re[k*W +: W] = re;
        bus.pole_im[k*W +: W] = im;
    endtask

    // Called #1 after an edge with the DUT idle and the frame already on the bus.
    task automatic run_frame(input string tag, input int exp_phase, input int hold);
        int cyc;
        int rdy_bad;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        // Scramble the buses: the running frame must not see these.
        bus.zero_re = {$urandom, $urandom};
        bus.zero_im = {$urandom, $urandom};
        bus.pole_re = {$urandom, $urandom};
        bus.pole_im = {$urandom, $urandom};
        check_eq({tag, " busy"}, int'(bus.busy), 1);
        cyc     = 0;
        rdy_bad = 0;
        while (!bus.out_valid && cyc < 40) begin
            if (bus.in_ready) rdy_bad++;
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({tag, " latency"}, cyc + 1, Latency);
        check_eq({tag, " in_ready_low"}, rdy_bad + int'(bus.in_ready), 0);
        check_eq({tag, " phase"}, int'(bus.phase_out), exp_phase);
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            check_eq({tag, " hold_valid"}, int'(bus.out_valid), 1);
            check_eq({tag, " hold_phase"}, int'(bus.phase_out), exp_phase);
            check_eq({tag, " hold_in_ready"}, int'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_eq({tag, " post_valid"}, int'(bus.out_valid), 0);
        check_eq({tag, " post_in_ready"}, int'(bus.in_ready), 1);
        check_eq({tag, " post_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        int seen;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        load_all(16'sd0, 16'sd0, 16'sd0, 16'sd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset in_ready", int'(bus.in_ready), 1);
        check_eq("reset out_valid", int'(bus.out_valid), 0);
        check_eq("reset busy", int'(bus.busy), 0);
        check_eq("reset phase", int'(bus.phase_out), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        load_all(16'sd1, 16'sd0, 16'sd1, 16'sd0);
        run_frame("t1 all_unit", 0, 0);

        load_all(16'sd1, 16'sd0, 16'sd1, 16'sd0);
        set_zero(0, 16'sd0, 16'sd1);
        run_frame("t2 zero0_j", 12868, 0);

        load_all(16'sd1, 16'sd0, 16'sd1, 16'sd0);
        set_pole(0, 16'sd0, 16'sd1);
        run_frame("t2 pole0_j", -12868, 0);

        // 4*pi + 4*pi/2 = 154416 wraps to 23344.
        load_all(-16'sd1, 16'sd0, 16'sd0, -16'sd1);
        run_frame("t3 wrap_pos", 23344, 0);

        // -4*pi/2 - 4*pi = -154416 wraps to -23344.
        load_all(16'sd0, -16'sd1, -16'sd1, 16'sd0);
        run_frame("t3 wrap_neg", -23344, 0);

        // pi from zero[1], +pi/2 from pole[2]: 38604 wraps to -26932.
        load_all(16'sd3, 16'sd0, 16'sd3, 16'sd0);
        set_zero(1, -16'sd5, 16'sd0);
        set_pole(2, 16'sd0, -16'sd7);
        run_frame("t3 index_mix", -26932, 0);

        load_all(16'sd1, 16'sd0, 16'sd1, 16'sd0);
        set_zero(3, 16'sd0, 16'sd9);
        run_frame("t4 hold", 12868, 5);

        load_all(16'sd1, 16'sd0, 16'sd1, 16'sd0);
        set_zero(0, 16'sd0, 16'sd1);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("t5 rst out_valid", int'(bus.out_valid), 0);
        check_eq("t5 rst in_ready", int'(bus.in_ready), 1);
        check_eq("t5 rst busy", int'(bus.busy), 0);
        check_eq("t5 rst phase", int'(bus.phase_out), 0);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check_eq("t5 no_out_valid", seen, 0);
        check_eq("t5 in_ready_after", int'(bus.in_ready), 1);

        load_all(16'sd1, 16'sd0, 16'sd1, 16'sd0);
        set_pole(3, -16'sd2, 16'sd0);
        run_frame("t5 next_frame", -25736, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
